warp_reg_file: RTL and testbench

Per-thread register file for one SIMT lane. It supplies the `rs1`/`rs2` operands consumed by the lane's ALU and writes results back into the register file. Results can come from the ALU, the LSU, the link value (pc+4) or the immediate. One instance sits beside each ALU and each LSU lane, and all lanes are sequenced by the shared warp state. Register reads are captured during decode. Writeback is committed during update, so operands are stable for the whole execute phase.

---
 rtl/warp_reg_file.sv | 143 ++++++++++++++
 tb/tb_warp_reg_file.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/warp_reg_file.sv
// warp_reg_file: per-thread register file for one SIMT lane.
//
// Operands are captured on decode edges and held through execute. Writeback
// is committed on update edges from one of four sources (ALU, LSU, pc+4, imm).
// x0 reads as zero.
//
// Optional feature macro: REG_SPECIAL_EN
//   defined   : x29 = THREAD_ID, x30 = block_id, x31 = block_dim (read-only)
//   undefined : x29..x31 are ordinary registers; block_id/block_dim/THREAD_ID unused
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   warp_state             shared warp phase (reads in DECODE, writes in UPDATE)
//   enable                 lane active; low freezes all state
//   block_id, block_dim    special register sources (REG_SPECIAL_EN only)
//   rs1_addr, rs2_addr     read addresses
//   rd_addr, RegWrite      write address and request
//   RegMux                 writeback source: 0 alu_out, 1 lsu_out, 2 pc+4, 3 imm
//   alu_out, lsu_out, pc, imm   writeback sources
//   rs1, rs2               registered operands

package warp_reg_file_pkg;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IMEM_ADDR_W = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]      data_t;
  typedef logic [IMEM_ADDR_W-1:0] instr_mem_addr_t;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_EXECUTE = 3'd3,
    WARP_MEMORY  = 3'd4,
    WARP_UPDATE  = 3'd5,
    WARP_DONE    = 3'd6
  } warp_state_t;
endpackage

module warp_reg_file
  import warp_reg_file_pkg::*;
#(
  parameter int          THREAD_ID = 0,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  warp_state_t           warp_state,
  input  logic                  enable,
  input  data_t                 block_id,
  input  data_t                 block_dim,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  RegWrite,
  input  logic [1:0]            RegMux,
  input  data_t                 alu_out,
  input  data_t                 lsu_out,
  input  instr_mem_addr_t       pc,
  input  data_t                 imm,
  output data_t                 rs1,
  output data_t                 rs2
);

`ifdef REG_SPECIAL_EN
  // Top three addresses are special registers with no storage behind them.
  localparam int unsigned LAST_GPR = NUM_REGS - 4;
`else
  localparam int unsigned LAST_GPR = NUM_REGS - 1;

  logic unused_special;
  assign unused_special = ^{block_id, block_dim, DATA_W'(THREAD_ID)};
`endif

  data_t regs [1:LAST_GPR];
  data_t rs1_c;
  data_t rs2_c;
  data_t wb_data_c;
  logic  rd_phase_c;
  logic  wr_en_c;

  assign rd_phase_c = enable && (warp_state == WARP_DECODE);
  assign wr_en_c    = enable && RegWrite && (warp_state == WARP_UPDATE);

  // Writeback source select; pc+4 wraps modulo 2^32.
  always_comb begin
    wb_data_c = alu_out;
    case (RegMux)
      2'd0:    wb_data_c = alu_out;
      2'd1:    wb_data_c = lsu_out;
      2'd2:    wb_data_c = DATA_W'(pc) + DATA_W'(4);
      default: wb_data_c = imm;
    endcase
  end

  // Operand read mux; unmatched addresses (x0) fall through to zero.
  always_comb begin
    rs1_c = '0;
    rs2_c = '0;
    for (int unsigned i = 1; i <= LAST_GPR; i++) begin
      if (rs1_addr == REG_ADDR_W'(i)) rs1_c = regs[i];
      if (rs2_addr == REG_ADDR_W'(i)) rs2_c = regs[i];
    end
`ifdef REG_SPECIAL_EN
    case (rs1_addr)
      5'd29:   rs1_c = DATA_W'(THREAD_ID);
      5'd30:   rs1_c = block_id;
      5'd31:   rs1_c = block_dim;
      default: ;
    endcase
    case (rs2_addr)
      5'd29:   rs2_c = DATA_W'(THREAD_ID);
      5'd30:   rs2_c = block_id;
      5'd31:   rs2_c = block_dim;
      default: ;
    endcase
`endif
  end

  // Register storage; writes to x0 or non-storage addresses match no entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 1; i <= LAST_GPR; i++) regs[i] <= '0;
    end else if (wr_en_c) begin
      for (int unsigned i = 1; i <= LAST_GPR; i++) begin
        if (rd_addr == REG_ADDR_W'(i)) regs[i] <= wb_data_c;
      end
    end
  end

  // Operand capture on decode edges only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1 <= '0;
      rs2 <= '0;
    end else if (rd_phase_c) begin
      rs1 <= rs1_c;
      rs2 <= rs2_c;
    end
  end

endmodule

// File: tb/tb_warp_reg_file.sv
module tb_warp_reg_file;
  import warp_reg_file_pkg::*;

  logic            clk;
  logic            reset;
  warp_state_t     warp_state;
  logic            enable;
  data_t           block_id;
  data_t           block_dim;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic            RegWrite;
  logic [1:0]      RegMux;
  data_t           alu_out;
  data_t           lsu_out;
  instr_mem_addr_t pc;
  data_t           imm;
  data_t           rs1;
  data_t           rs2;

  int n_tests = 0;
  int n_fail  = 0;

  warp_reg_file #(.THREAD_ID(3), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .warp_state(warp_state), .enable(enable),
    .block_id(block_id), .block_dim(block_dim),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .RegWrite(RegWrite), .RegMux(RegMux),
    .alu_out(alu_out), .lsu_out(lsu_out), .pc(pc), .imm(imm),
    .rs1(rs1), .rs2(rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Update-phase writeback; the chosen source carries val, others carry decoys.
  task automatic wr(input logic [4:0] rd, input logic [1:0] mux, input data_t val,
                    input logic en);
    warp_state = WARP_UPDATE;
    enable     = en;
    RegWrite   = 1'b1;
    rd_addr    = rd;
    RegMux     = mux;
    alu_out    = (mux == 2'd0) ? val : 32'hA1A1_0000;
    lsu_out    = (mux == 2'd1) ? val : 32'hB2B2_0000;
    imm        = (mux == 2'd3) ? val : 32'hC3C3_0000;
    pc         = (mux == 2'd2) ? val : 32'h0000_1000;
    tick();
    RegWrite   = 1'b0;
    enable     = 1'b1;
    warp_state = WARP_IDLE;
    tick();
  endtask

  // Decode edge followed by an execute edge; operands sampled after execute.
  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    warp_state = WARP_DECODE;
    rs1_addr   = a1;
    rs2_addr   = a2;
    tick();
    warp_state = WARP_EXECUTE;
    rs1_addr   = 5'd0;
    rs2_addr   = 5'd0;
    tick();
  endtask

  task automatic test_reset();
    n_tests++;
    if (rs1 !== 32'h0) begin n_fail++; $display("FAIL reset_rs1: got %h expected %h", rs1, 32'h0); end
    n_tests++;
    if (rs2 !== 32'h0) begin n_fail++; $display("FAIL reset_rs2: got %h expected %h", rs2, 32'h0); end
    rd(5'd5, 5'd28);
    n_tests++;
    if (rs1 !== 32'h0) begin n_fail++; $display("FAIL reset_x5: got %h expected %h", rs1, 32'h0); end
    n_tests++;
    if (rs2 !== 32'h0) begin n_fail++; $display("FAIL reset_x28: got %h expected %h", rs2, 32'h0); end
  endtask

  task automatic test_write_read();
    wr(5'd5, 2'd0, 32'hDEAD_BEEF, 1'b1);
    warp_state = WARP_DECODE; rs1_addr = 5'd5; rs2_addr = 5'd0;
    tick();
    n_tests++;
    if (rs1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd_rs1: got %h expected %h", rs1, 32'hDEAD_BEEF); end
    n_tests++;
    if (rs2 !== 32'h0) begin n_fail++; $display("FAIL wr_rd_rs2: got %h expected %h", rs2, 32'h0); end
    warp_state = WARP_EXECUTE; rs1_addr = 5'd9; rs2_addr = 5'd9;
    tick();
    n_tests++;
    if (rs1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL exec_stable: got %h expected %h", rs1, 32'hDEAD_BEEF); end
    wr(5'd6, 2'd1, 32'h1111_2222, 1'b1);
    wr(5'd7, 2'd3, 32'h3333_4444, 1'b1);
    rd(5'd6, 5'd7);
    n_tests++;
    if (rs1 !== 32'h1111_2222) begin n_fail++; $display("FAIL lsu_src: got %h expected %h", rs1, 32'h1111_2222); end
    n_tests++;
    if (rs2 !== 32'h3333_4444) begin n_fail++; $display("FAIL imm_src: got %h expected %h", rs2, 32'h3333_4444); end
    rd(5'd5, 5'd5);
    n_tests++;
    if (rs1 !== 32'hDEAD_BEEF || rs2 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL same_addr: got %h/%h expected %h", rs1, rs2, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_link();
    wr(5'd1, 2'd2, 32'hFFFF_FFFC, 1'b1);
    wr(5'd2, 2'd2, 32'h0000_0100, 1'b1);
    rd(5'd1, 5'd2);
    n_tests++;
    if (rs1 !== 32'h0) begin n_fail++; $display("FAIL link_wrap: got %h expected %h", rs1, 32'h0); end
    n_tests++;
    if (rs2 !== 32'h0000_0104) begin n_fail++; $display("FAIL link_plus4: got %h expected %h", rs2, 32'h0000_0104); end
  endtask

  task automatic test_x0_disable();
    wr(5'd0, 2'd0, 32'h0000_1234, 1'b1);
    rd(5'd0, 5'd0);
    n_tests++;
    if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
      n_fail++; $display("FAIL x0_write: got %h/%h expected %h", rs1, rs2, 32'h0);
    end
    wr(5'd7, 2'd0, 32'h0BAD_0BAD, 1'b0);
    rd(5'd7, 5'd6);
    n_tests++;
    if (rs1 !== 32'h3333_4444) begin n_fail++; $display("FAIL disabled_write: got %h expected %h", rs1, 32'h3333_4444); end
    enable = 1'b0;
    warp_state = WARP_DECODE; rs1_addr = 5'd5; rs2_addr = 5'd1;
    tick(); tick();
    enable = 1'b1; warp_state = WARP_IDLE;
    n_tests++;
    if (rs1 !== 32'h3333_4444 || rs2 !== 32'h1111_2222) begin
      n_fail++; $display("FAIL disabled_read: got %h/%h expected %h/%h", rs1, rs2, 32'h3333_4444, 32'h1111_2222);
    end
  endtask

  task automatic test_special();
    block_id  = 32'd9;
    block_dim = 32'd64;
    wr(5'd29, 2'd3, 32'h0000_0055, 1'b1);
    rd(5'd29, 5'd30);
`ifdef REG_SPECIAL_EN
    n_tests++;
    if (rs1 !== 32'd3) begin n_fail++; $display("FAIL x29_thread: got %h expected %h", rs1, 32'd3); end
    n_tests++;
    if (rs2 !== 32'd9) begin n_fail++; $display("FAIL x30_block_id: got %h expected %h", rs2, 32'd9); end
`else
    n_tests++;
    if (rs1 !== 32'h55) begin n_fail++; $display("FAIL x29_gpr: got %h expected %h", rs1, 32'h55); end
    n_tests++;
    if (rs2 !== 32'h0) begin n_fail++; $display("FAIL x30_gpr: got %h expected %h", rs2, 32'h0); end
`endif
  endtask

  task automatic test_async_reset();
    wr(5'd10, 2'd0, 32'hA5A5_A5A5, 1'b1);
    rd(5'd10, 5'd10);
    n_tests++;
    if (rs1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL preload_x10: got %h expected %h", rs1, 32'hA5A5_A5A5); end
    warp_state = WARP_EXECUTE;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got %h/%h expected %h", rs1, rs2, 32'h0);
    end
    #2;
    reset = 1'b0;
    tick();
    rd(5'd10, 5'd5);
    n_tests++;
    if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_regs: got %h/%h expected %h", rs1, rs2, 32'h0);
    end
  endtask

  task automatic test_phase_gating();
    wr(5'd12, 2'd0, 32'h0000_0077, 1'b1);
    wr(5'd5,  2'd0, 32'h0000_0088, 1'b1);
    rd(5'd12, 5'd12);
    n_tests++;
    if (rs1 !== 32'h77) begin n_fail++; $display("FAIL gate_preload: got %h expected %h", rs1, 32'h77); end
    RegWrite = 1'b1; rd_addr = 5'd12; RegMux = 2'd0; alu_out = 32'h99;
    warp_state = WARP_EXECUTE; tick();
    warp_state = WARP_DECODE; rs1_addr = 5'd12; rs2_addr = 5'd12; tick();
    RegWrite = 1'b0;
    warp_state = WARP_UPDATE; rs1_addr = 5'd5; rs2_addr = 5'd5; tick();
    warp_state = WARP_IDLE;
    n_tests++;
    if (rs1 !== 32'h77 || rs2 !== 32'h77) begin
      n_fail++; $display("FAIL update_no_read: got %h/%h expected %h", rs1, rs2, 32'h77);
    end
    rd(5'd12, 5'd5);
    n_tests++;
    if (rs1 !== 32'h77) begin n_fail++; $display("FAIL no_write_outside_update: got %h expected %h", rs1, 32'h77); end
    n_tests++;
    if (rs2 !== 32'h88) begin n_fail++; $display("FAIL gate_x5: got %h expected %h", rs2, 32'h88); end
  endtask

  initial begin
    reset      = 1'b1;
    warp_state = WARP_IDLE;
    enable     = 1'b1;
    block_id   = '0;
    block_dim  = '0;
    rs1_addr   = '0;
    rs2_addr   = '0;
    rd_addr    = '0;
    RegWrite   = 1'b0;
    RegMux     = '0;
    alu_out    = '0;
    lsu_out    = '0;
    pc         = '0;
    imm        = '0;
    tick(); tick();
    reset = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_link();
    test_x0_disable();
    test_special();
    test_async_reset();
    test_phase_gating();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
